// File: rtl/cia_sp_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// cia_sp_pkg -- shared types/constants for the 6526 serial-port peer.  Rev 1.0
//------------------------------------------------------------------------------
package cia_sp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    FLAG = 2'd3
  } tx_state_e;

  localparam int unsigned c_sync_depth = 2;

endpackage : cia_sp_pkg
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
//------------------------------------------------------------------------------
// sync2 -- multi-flop input synchroniser, presets to 1 on reset.  Rev 1.0
//------------------------------------------------------------------------------
module sync2
  import cia_sp_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [c_sync_depth-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[c_sync_depth-2:0], d_i};
    end
  end

  assign q_o = sync_q[c_sync_depth-1];

endmodule : sync2
`default_nettype wire

// File: rtl/cia_sp_peer.sv
`default_nettype none
//------------------------------------------------------------------------------
// cia_sp_peer -- far-end partner for a 6526 serial port: RX, TX (CNT master), FLAG, PC.  Rev 1.0
//------------------------------------------------------------------------------
module cia_sp_peer
  import cia_sp_pkg::*;
#(
  parameter int unsigned CNT_HALF     = 8,
  parameter int unsigned IDLE_TIMEOUT = 1024,
  parameter int unsigned FLAG_LEN     = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       sp_out_i,
  input  logic       cnt_out_i,
  output logic       sp_in_o,
  output logic       cnt_in_o,
  output logic       flag_n_o,
  input  logic       pc_n_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_overrun_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       flag_en_i,
  output logic       pc_strobe_o
);

  localparam int unsigned c_tmr_max = (CNT_HALF > FLAG_LEN) ? CNT_HALF : FLAG_LEN;
  localparam int unsigned c_tmr_w   = $clog2(c_tmr_max + 1);
  localparam int unsigned c_idle_w  = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [c_tmr_w-1:0]  c_half_last = c_tmr_w'(CNT_HALF - 1);
  localparam logic [c_tmr_w-1:0]  c_flag_last = c_tmr_w'(FLAG_LEN - 1);
  localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(IDLE_TIMEOUT - 1);

  logic w_sp_sync;
  logic w_cnt_sync;
  logic w_pc_sync;

  sync2 u_sync_sp  (.clk_i(clk_i), .reset_i(reset_i), .d_i(sp_out_i),  .q_o(w_sp_sync));
  sync2 u_sync_cnt (.clk_i(clk_i), .reset_i(reset_i), .d_i(cnt_out_i), .q_o(w_cnt_sync));
  sync2 u_sync_pc  (.clk_i(clk_i), .reset_i(reset_i), .d_i(pc_n_i),    .q_o(w_pc_sync));

  // ---------------------------------------------------------------- RX path
  logic [6:0]          rx_shift_q;
  logic [6:0]          rx_shift_d;
  logic [7:0]          rx_byte_d;
  logic [2:0]          rx_bitcnt_q;
  logic [c_idle_w-1:0] rx_idle_q;
  logic [7:0]          rx_data_q;
  logic                rx_valid_q;
  logic                rx_overrun_q;
  logic                cnt_prev_q;
  logic                w_cnt_rise;
  logic                w_rx_done;

  assign w_cnt_rise = w_cnt_sync & ~cnt_prev_q;
  assign w_rx_done  = w_cnt_rise & (rx_bitcnt_q == 3'd7);
  assign rx_shift_d = {rx_shift_q[5:0], w_sp_sync};
  assign rx_byte_d  = {rx_shift_q, w_sp_sync};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_prev_q   <= 1'b1;
      rx_shift_q   <= '0;
      rx_bitcnt_q  <= '0;
      rx_idle_q    <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      cnt_prev_q <= w_cnt_sync;

      if (w_cnt_rise) begin
        rx_shift_q  <= rx_shift_d;
        rx_bitcnt_q <= rx_bitcnt_q + 3'd1;
        rx_idle_q   <= '0;
      end else if (rx_bitcnt_q != 3'd0) begin
        // A stalled partial byte is dropped so the next byte starts aligned.
        if (rx_idle_q == c_idle_last) begin
          rx_shift_q  <= '0;
          rx_bitcnt_q <= '0;
          rx_idle_q   <= '0;
        end else begin
          rx_idle_q <= rx_idle_q + c_idle_w'(1);
        end
      end

      if (w_rx_done) begin
        rx_data_q  <= rx_byte_d;
        rx_valid_q <= 1'b1;
        if (rx_valid_q && !rx_ready_i) begin
          rx_overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_e          tx_state_q;
  logic [7:0]         tx_byte_q;
  logic [2:0]         tx_idx_q;
  logic [c_tmr_w-1:0] tx_tmr_q;
  logic               tx_flag_q;
  logic               sp_in_q;
  logic               cnt_in_q;
  logic               flag_n_q;
  logic               tx_ready_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_state_q <= IDLE;
      tx_byte_q  <= '0;
      tx_idx_q   <= '0;
      tx_tmr_q   <= '0;
      tx_flag_q  <= 1'b0;
      sp_in_q    <= 1'b1;
      cnt_in_q   <= 1'b1;
      flag_n_q   <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      case (tx_state_q)
        IDLE: begin
          if (tx_valid_i) begin
            tx_byte_q  <= tx_data_i;
            tx_flag_q  <= flag_en_i;
            tx_idx_q   <= 3'd7;
            tx_tmr_q   <= '0;
            sp_in_q    <= tx_data_i[7];
            cnt_in_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_state_q <= LOW;
          end
        end
        LOW: begin
          if (tx_tmr_q == c_half_last) begin
            tx_tmr_q   <= '0;
            cnt_in_q   <= 1'b1;
            tx_state_q <= HIGH;
          end else begin
            tx_tmr_q <= tx_tmr_q + c_tmr_w'(1);
          end
        end
        HIGH: begin
          if (tx_tmr_q == c_half_last) begin
            tx_tmr_q <= '0;
            if (tx_idx_q == 3'd0) begin
              flag_n_q   <= ~tx_flag_q;
              tx_state_q <= FLAG;
            end else begin
              // Data only moves with the CNT fall, giving a full half-period of setup.
              tx_idx_q   <= tx_idx_q - 3'd1;
              sp_in_q    <= tx_byte_q[tx_idx_q - 3'd1];
              cnt_in_q   <= 1'b0;
              tx_state_q <= LOW;
            end
          end else begin
            tx_tmr_q <= tx_tmr_q + c_tmr_w'(1);
          end
        end
        FLAG: begin
          if (!tx_flag_q || (tx_tmr_q == c_flag_last)) begin
            flag_n_q   <= 1'b1;
            sp_in_q    <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_state_q <= IDLE;
          end else begin
            tx_tmr_q <= tx_tmr_q + c_tmr_w'(1);
          end
        end
        default: tx_state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- PC edge
  logic pc_prev_q;
  logic pc_strobe_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_prev_q   <= 1'b1;
      pc_strobe_q <= 1'b0;
    end else begin
      pc_prev_q   <= w_pc_sync;
      pc_strobe_q <= pc_prev_q & ~w_pc_sync;
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign rx_overrun_o = rx_overrun_q;
  assign sp_in_o      = sp_in_q;
  assign cnt_in_o     = cnt_in_q;
  assign flag_n_o     = flag_n_q;
  assign tx_ready_o   = tx_ready_q;
  assign pc_strobe_o  = pc_strobe_q;

endmodule : cia_sp_peer
`default_nettype wire

// File: tb/tb_cia_sp_peer.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_cia_sp_peer -- directed stimulus with a cycle-level reference model.  Rev 1.0
//------------------------------------------------------------------------------
module tb_cia_sp_peer;

  localparam int H   = 8;
  localparam int FL  = 4;
  localparam int RXH = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sp_out = 1'b1, cnt_out = 1'b1, pc_n = 1'b1;
  logic       sp_in, cnt_in, flag_n;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready = 1'b0, rx_overrun;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, tx_ready, flag_en = 1'b0;
  logic       pc_strobe;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int pc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cia_sp_peer #(.CNT_HALF(H), .IDLE_TIMEOUT(1024), .FLAG_LEN(FL)) u_dut (
    .clk_i(clk), .reset_i(reset), .sp_out_i(sp_out), .cnt_out_i(cnt_out),
    .sp_in_o(sp_in), .cnt_in_o(cnt_in), .flag_n_o(flag_n), .pc_n_i(pc_n),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .rx_overrun_o(rx_overrun), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .flag_en_i(flag_en), .pc_strobe_o(pc_strobe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model: events the bench scheduled itself
  typedef struct { int cyc; logic [7:0] data; } rx_ev_t;
  rx_ev_t     due_q[$];
  int         pc_q[$];
  bit         chk_en = 0;
  logic       m_valid = 0, m_ovr = 0, m_pc = 0;
  logic [7:0] m_data = 0;
  bit         tx_busy = 0, tx_flag = 0;
  int         t0 = 0;
  logic [7:0] tx_byte = 0;
  int         tm, fdur;
  logic       e_cnt, e_sp, e_flag, e_rdy;

  always @(negedge clk) begin
    if (pc_strobe === 1'b1) pc_cnt++;
    fdur = tx_flag ? FL : 1;
    if (chk_en) begin
      if (tx_busy) begin
        tm = cyc - t0;
        if (tm < 16*H) begin
          e_cnt = ((tm / H) % 2) == 1;
          e_sp = tx_byte[7 - tm/(2*H)];
          e_flag = 1'b1;
        end else begin
          e_cnt = 1'b1;
          e_sp = tx_byte[0];
          e_flag = !tx_flag;
        end
        e_rdy = 1'b0;
      end else begin
        e_cnt = 1'b1; e_sp = 1'b1; e_flag = 1'b1; e_rdy = 1'b1;
      end
      chk("m_rx_valid", rx_valid, m_valid);
      chk("m_rx_data", rx_data, m_data);
      chk("m_rx_overrun", rx_overrun, m_ovr);
      chk("m_pc_strobe", pc_strobe, m_pc);
      chk("m_cnt_in", cnt_in, e_cnt);
      chk("m_sp_in", sp_in, e_sp);
      chk("m_flag_n", flag_n, e_flag);
      chk("m_tx_ready", tx_ready, e_rdy);
    end
    // advance the model to the next cycle
    if (reset) begin
      chk_en = 1; m_valid = 0; m_ovr = 0; m_pc = 0; m_data = 0;
      tx_busy = 0; due_q.delete(); pc_q.delete();
    end else begin
      if (due_q.size() > 0 && due_q[0].cyc == cyc + 1) begin
        if (m_valid && !rx_ready) m_ovr = 1;
        m_valid = 1;
        m_data = due_q[0].data;
        void'(due_q.pop_front());
      end else if (m_valid && rx_ready) begin
        m_valid = 0;
      end
      m_pc = 0;
      if (pc_q.size() > 0 && pc_q[0] == cyc + 1) begin
        m_pc = 1;
        void'(pc_q.pop_front());
      end
      if (!tx_busy && tx_valid) begin
        tx_busy = 1; t0 = cyc + 1; tx_byte = tx_data; tx_flag = flag_en;
      end else if (tx_busy && (cyc + 1 - t0) >= 16*H + fdur) begin
        tx_busy = 0;
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rx_send(input logic [7:0] b, input bit ack);
    for (int i = 7; i >= 0; i--) begin
      sp_out = b[i];
      cnt_out = 1'b0;
      repeat (RXH) tick;
      cnt_out = 1'b1;
      if (i == 0) begin
        due_q.push_back('{cyc: cyc + 3, data: b});
        if (ack) begin
          tick; tick;
          rx_ready = 1'b1;
          tick;
          rx_ready = 1'b0;
          repeat (RXH - 3) tick;
        end else begin
          repeat (RXH) tick;
        end
      end else begin
        repeat (RXH) tick;
      end
    end
  endtask

  task automatic rx_consume;
    rx_ready = 1'b1;
    tick;
    rx_ready = 1'b0;
  endtask

  task automatic start_tx(input logic [7:0] d, input logic f, output int acc);
    for (int i = 0; i < 300 && tx_ready !== 1'b1; i++) tick;
    tx_data = d; flag_en = f; tx_valid = 1'b1;
    acc = cyc;
    tick;
    tx_valid = 1'b0;
  endtask

  task automatic tx_watch(input int acc, input logic [7:0] exp_b, input int exp_fl, input int exp_rdy);
    int lows = 0, lowlen = 0, badw = 0, fl = 0, rdy_at = -1;
    logic [7:0] bits = 8'h00;
    logic pcnt = 1'b1;
    for (int i = 0; i < 400 && rdy_at < 0; i++) begin
      @(negedge clk);
      if (!cnt_in) lowlen = pcnt ? 1 : lowlen + 1;
      if (!pcnt && cnt_in) begin
        bits = {bits[6:0], sp_in};
        lows++;
        if (lowlen != H) badw++;
      end
      if (!flag_n) fl++;
      if (tx_ready) rdy_at = cyc - acc;
      pcnt = cnt_in;
    end
    chk("tx_low_pulses", lows, 8);
    chk("tx_low_width_errs", badw, 0);
    chk("tx_bits", bits, exp_b);
    chk("tx_flag_len", fl, exp_fl);
    chk("tx_ready_delay", rdy_at, exp_rdy);
    tick;
  endtask

  int acc;

  initial begin
    repeat (3) tick;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sp_in", sp_in, 1);
    chk("rst_cnt_in", cnt_in, 1);
    chk("rst_flag_n", flag_n, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_pc_strobe", pc_strobe, 0);
    tick;

    // single byte receive and consume
    rx_send(8'hA5, 0);
    @(negedge clk);
    chk("rx_a5_valid", rx_valid, 1);
    chk("rx_a5_data", rx_data, 8'hA5);
    chk("rx_a5_ovr", rx_overrun, 0);
    tick;
    rx_consume;
    @(negedge clk);
    chk("rx_consumed", rx_valid, 0);
    tick;

    // overrun, then completion coinciding with a handshake
    rx_send(8'h3C, 0);
    rx_send(8'hC3, 0);
    @(negedge clk);
    chk("ovr_data", rx_data, 8'hC3);
    chk("ovr_flag", rx_overrun, 1);
    tick;
    reset = 1'b1; tick; reset = 1'b0;
    rx_send(8'h11, 0);
    rx_send(8'h22, 1);
    @(negedge clk);
    chk("ack_valid", rx_valid, 1);
    chk("ack_data", rx_data, 8'h22);
    chk("ack_no_ovr", rx_overrun, 0);
    tick;
    rx_consume;

    // partial byte, long idle, then a clean byte
    for (int i = 0; i < 3; i++) begin
      sp_out = 1'b1; cnt_out = 1'b0; repeat (RXH) tick;
      cnt_out = 1'b1; repeat (RXH) tick;
    end
    repeat (1024) tick;
    rx_send(8'h5A, 0);
    @(negedge clk);
    chk("resync_data", rx_data, 8'h5A);
    tick;
    rx_consume;

    // transmit with FLAG
    start_tx(8'h96, 1'b1, acc);
    tx_watch(acc, 8'h96, FL, 16*H + FL + 1);

    // reset in the middle of a transmission, then a clean byte
    start_tx(8'hF0, 1'b1, acc);
    repeat (9*H - 1) tick;
    reset = 1'b1; tick; reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_cnt_in", cnt_in, 1);
    chk("mid_rst_sp_in", sp_in, 1);
    chk("mid_rst_tx_ready", tx_ready, 1);
    chk("mid_rst_flag_n", flag_n, 1);
    tick;
    start_tx(8'h5C, 1'b0, acc);
    tx_watch(acc, 8'h5C, 0, 16*H + 2);

    // RX and TX together
    fork
      rx_send(8'h69, 0);
      begin
        int a2;
        start_tx(8'hA3, 1'b0, a2);
        tx_watch(a2, 8'hA3, 0, 16*H + 2);
      end
    join
    @(negedge clk);
    chk("dual_rx_data", rx_data, 8'h69);
    tick;
    rx_consume;

    // PC strobes
    pc_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      pc_n = 1'b0;
      pc_q.push_back(cyc + 3);
      repeat (5) tick;
      pc_n = 1'b1;
      repeat (5) tick;
    end
    repeat (5) tick;
    chk("pc_strobe_count", pc_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_cia_sp_peer
`default_nettype wire
